mips32_prog_loader: RTL and testbench
=====================================

Name: mips32_prog_loader

Overview:
Boot-time program loader that sits upstream of the two-phase MIPS32 core and its unified memory. It receives a byte-serial program image over a valid/ready stream, assembles big-endian 32-bit instruction words, writes them into memory from BASE_ADDR upward, and verifies a trailing checksum. It holds the core halted throughout, then releases it with a one-cycle start pulse so the core fetches from PC=0.

Parameters:
ADDR_W, 10, memory word-address width
BASE_ADDR, 0, word address of the first loaded instruction
MAX_WORDS, 1024, largest accepted word count; larger counts are rejected
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk1  in  1  loader clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  8  stream byte
in_valid  in  1  in_data is valid
in_ready  out  1  loader accepts the byte; a byte transfers when in_valid && in_ready
mem_we  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_W  word write address
mem_wdata  out  32  assembled instruction word
cpu_hold  out  1  core held halted (drives core HALTED / PC reset)
cpu_start  out  1  one-cycle pulse: core PC<=0, HALTED<=0, TAKEN_BRANCH<=0
busy  out  1  frame in progress
done  out  1  sticky: last frame loaded and checksum matched
err  out  2  00 none, 01 checksum mismatch, 10 count > MAX_WORDS

Behaviour:
- Reset (async, any state): state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_start=0, busy=0, done=0, err=00, sum=0, count=0.
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO, then count words (4 bytes each, MSB first), then CSUM. CSUM = 8-bit sum mod 256 of all data bytes only.
- IDLE: in_ready=1. Non-sync bytes are discarded. A sync byte moves to CNT_HI and sets busy=1, cpu_hold=1, done=0, err=00, sum=0.
- CNT_HI and CNT_LO each take one byte to form the 16-bit count.
- Count check after CNT_LO:
  - count > MAX_WORDS: err=10, go to IDLE, busy=0, cpu_hold stays 1.
  - count = 0: go straight to CSUM.
  - otherwise: go to DATA with byte index 0 and word index 0.
- DATA: each accepted byte shifts into the word register (first byte lands in [31:24]) and is added to sum. When byte index 3 is accepted, go to WRITE.
- WRITE: lasts exactly one cycle.
  - in_ready=0, mem_we=1, mem_addr = BASE_ADDR + word index (mod 2^ADDR_W), mem_wdata = assembled word.
  - Word index increments. If it now equals count, go to CSUM; else return to DATA.
  - Load throughput is therefore one word per 5 clk1 cycles at most.
- mem_we is never high outside WRITE. mem_addr and mem_wdata hold their last values when mem_we=0.
- CSUM: one byte is accepted.
  - If it equals sum: go to START.
  - Otherwise: err=01, go to IDLE, busy=0, cpu_hold=1.
- START: lasts one cycle. in_ready=0, cpu_start=1, cpu_hold falls to 0 in that same cycle, done=1, busy=0. Next state is IDLE.
- A sync byte arriving in IDLE after done begins a reload: cpu_hold rises to 1 in the cycle after the sync byte is accepted, and done clears.
- in_valid gaps may occur in any state; state holds until a byte transfers. in_data is ignored when in_valid=0.
- A sync-valued byte inside DATA, CNT, or CSUM is treated as data (no resynchronisation).
- Reset mid-frame: abort immediately. Words already written stay in memory. cpu_hold=1, no cpu_start.

Test Plan:
- Stream A5 00 01 28 01 00 78 A1 -> exactly one mem_we pulse: mem_addr=0, mem_wdata=32'h28010078. Then cpu_start pulses for 1 cycle, cpu_hold=0, done=1, err=00.
- Same frame with CSUM=A2 -> mem_we fires at addr 0, then err=01, no cpu_start, cpu_hold=1, done=0.
- A5 04 01 (count 1025, MAX_WORDS=1024) -> no mem_we, err=10, busy=0, in_ready=1. A following valid single-word frame succeeds and clears err.
- 8-word program (28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000) with correct CSUM and random in_valid gaps -> writes to addr 0..7 in order with matching data. in_ready=0 exactly during the 8 WRITE cycles and the START cycle. A single cpu_start follows.
- BASE_ADDR=1022 with count 3 -> writes at addresses 1022, 1023, 0 (wrap).
- Assert rst after the second data byte of a 2-word frame -> all outputs return to reset values asynchronously, no mem_we or cpu_start. A complete frame afterwards loads correctly.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Boot-time loader: takes a byte-serial framed program image, writes big-endian
// 32-bit words into core memory, verifies the checksum, then releases the core.
module mips32_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          BASE_ADDR = 0,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CSUM, S_START
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [7:0]          sum_q, sum_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;

  logic                xfer;
  logic [15:0]         cnt_full;
  logic [15:0]         widx_inc;

  assign in_ready  = (state_q != S_WRITE) && (state_q != S_START);
  assign xfer      = in_valid && in_ready;
  assign cnt_full  = {cnt_q[15:8], in_data};
  assign widx_inc  = widx_q + 16'd1;

  assign mem_we    = (state_q == S_WRITE);
  assign cpu_start = (state_q == S_START);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    sum_d   = sum_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d = S_CNT_HI;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 2'b00;
          sum_d   = 8'h00;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_d   = {in_data, 8'h00};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          cnt_d  = cnt_full;
          widx_d = 16'd0;
          bidx_d = 2'd0;
          if (32'(cnt_full) > 32'(MAX_WORDS)) begin
            err_d   = 2'b10;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (cnt_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[23:0], in_data};
          sum_d  = sum_q + in_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            // Address/data registers hold their value once the strobe drops.
            addr_d  = ADDR_W'(32'(BASE_ADDR) + 32'(widx_q));
            wdata_d = {word_q[23:0], in_data};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        widx_d  = widx_inc;
        state_d = (widx_inc == cnt_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (in_data == sum_q) begin
            hold_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_START;
          end else begin
            hold_d  = 1'b1;
            err_d   = 2'b01;
            state_d = S_IDLE;
          end
        end
      end
      S_START: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      sum_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      sum_q   <= sum_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader; a second instance with BASE_ADDR=1022
// shares the stream to observe address wrap.
module tb_mips32_prog_loader;

  logic        clk1;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready, mem_we, cpu_hold, cpu_start, busy, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err;

  logic        w_in_ready, w_mem_we, w_cpu_hold, w_cpu_start, w_busy, w_done;
  logic [9:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [1:0]  w_err;

  mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5)) dut (
    .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .cpu_start(cpu_start), .busy(busy), .done(done), .err(err)
  );

  mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(1022), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5)) dut_wrap (
    .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(w_in_ready),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .cpu_hold(w_cpu_hold),
    .cpu_start(w_cpu_start), .busy(w_busy), .done(w_done), .err(w_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Event recorders (only this process writes them).
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [9:0]  xa_q[$];
  int          start_cnt = 0;
  int          nrdy_cnt  = 0;

  always @(negedge clk1) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (w_mem_we) xa_q.push_back(w_mem_addr);
    if (cpu_start) start_cnt++;
    if (!in_ready) nrdy_cnt++;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      @(negedge clk1);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk1);
      guard++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] csum_xor, input int maxgap);
    logic [7:0] s;
    logic [31:0] w;
    s = 8'h00;
    send(8'hA5, 0);
    send(8'(wq.size() >> 8), $urandom_range(0, maxgap));
    send(8'(wq.size()), $urandom_range(0, maxgap));
    foreach (wq[i]) begin
      w = wq[i];
      for (int k = 3; k >= 0; k--) begin
        s = s + w[8*k +: 8];
        send(w[8*k +: 8], $urandom_range(0, maxgap));
      end
    end
    send(s ^ csum_xor, $urandom_range(0, maxgap));
    repeat (3) @(negedge clk1);
  endtask

  initial begin
    int wb, sb, nb, xb;
    logic [31:0] prog[8];
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {30'd0, err}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Single-word frame, good checksum (A1).
    wb = wa_q.size(); sb = start_cnt;
    send(8'h3C, 1);  // noise in IDLE is discarded
    wq = '{32'h28010078};
    send_frame(8'h00, 0);
    chk("t1_we_cnt", wa_q.size() - wb, 32'd1);
    chk("t1_addr", {22'd0, wa_q[wb]}, 32'd0);
    chk("t1_data", wd_q[wb], 32'h28010078);
    chk("t1_start", start_cnt - sb, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_err", {30'd0, err}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Same frame, checksum A2; also checks reload re-asserts hold.
    wb = wa_q.size(); sb = start_cnt;
    send(8'hA5, 0);
    chk("t2_hold_reload", {31'd0, cpu_hold}, 32'd1);
    chk("t2_done_clear", {31'd0, done}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    send(8'h00, 0); send(8'h01, 0);
    send(8'h28, 0); send(8'h01, 0); send(8'h00, 0); send(8'h78, 0);
    send(8'hA2, 0);
    repeat (3) @(negedge clk1);
    chk("t2_we_cnt", wa_q.size() - wb, 32'd1);
    chk("t2_addr", {22'd0, wa_q[wb]}, 32'd0);
    chk("t2_err", {30'd0, err}, 32'd1);
    chk("t2_start", start_cnt - sb, 32'd0);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t2_done", {31'd0, done}, 32'd0);

    // Count 1025 rejected, then a good frame clears err.
    wb = wa_q.size();
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0);
    repeat (2) @(negedge clk1);
    chk("t3_we_cnt", wa_q.size() - wb, 32'd0);
    chk("t3_err", {30'd0, err}, 32'd2);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
    wb = wa_q.size(); sb = start_cnt;
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h0c, 0); send(8'h63, 0); send(8'h18, 0); send(8'h00, 0);
    send(8'h87, 0);
    repeat (3) @(negedge clk1);
    chk("t3b_data", wd_q[wb], 32'h0c631800);
    chk("t3b_err", {30'd0, err}, 32'd0);
    chk("t3b_done", {31'd0, done}, 32'd1);
    chk("t3b_start", start_cnt - sb, 32'd1);

    // 8-word program with random valid gaps.
    wb = wa_q.size(); sb = start_cnt; nb = nrdy_cnt;
    wq.delete();
    foreach (prog[i]) wq.push_back(prog[i]);
    send_frame(8'h00, 3);
    chk("t4_we_cnt", wa_q.size() - wb, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_addr%0d", i), {22'd0, wa_q[wb + i]}, 32'(i));
      chk($sformatf("t4_data%0d", i), wd_q[wb + i], prog[i]);
    end
    chk("t4_nrdy", nrdy_cnt - nb, 32'd9);
    chk("t4_start", start_cnt - sb, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd1);

    // Three words: wrap instance writes 1022, 1023, 0.
    wb = wa_q.size(); xb = xa_q.size();
    wq = '{32'h11223344, 32'h55667788, 32'h99aabbcc};
    send_frame(8'h00, 1);
    chk("t5_wrap_cnt", xa_q.size() - xb, 32'd3);
    chk("t5_wrap0", {22'd0, xa_q[xb]}, 32'd1022);
    chk("t5_wrap1", {22'd0, xa_q[xb + 1]}, 32'd1023);
    chk("t5_wrap2", {22'd0, xa_q[xb + 2]}, 32'd0);
    chk("t5_main2", {22'd0, wa_q[wb + 2]}, 32'd2);
    chk("t5_wrap_done", {31'd0, w_done}, 32'd1);

    // Reset after second data byte of a 2-word frame.
    wb = wa_q.size(); sb = start_cnt;
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h11, 0); send(8'h22, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_err", {30'd0, err}, 32'd0);
    chk("t6_addr", {22'd0, mem_addr}, 32'd0);
    chk("t6_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    repeat (2) @(negedge clk1);
    chk("t6_no_we", wa_q.size() - wb, 32'd0);
    chk("t6_no_start", start_cnt - sb, 32'd0);
    wb = wa_q.size(); sb = start_cnt;
    wq = '{32'h24220001};
    send_frame(8'h00, 0);
    chk("t6b_data", wd_q[wb], 32'h24220001);
    chk("t6b_start", start_cnt - sb, 32'd1);
    chk("t6b_done", {31'd0, done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
